regfile_wr_arbiter: RTL and testbench

//  Shares the two write ports of the 16-entry register file among NREQ writeback

---
 rtl/regfile_wr_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-port round-robin writeback arbiter for the register file
//
// Purpose:
//   Shares the two write ports of the register file among NREQ writeback
//   requesters. Up to two writes are granted per cycle in round-robin order.
//   Two writes to the same register are never granted in the same cycle.
//   The register-file write bus is driven from registers, one cycle after acceptance.
//
// Ports:
//   clk          clock, all state updates on posedge
//   resetn       asynchronous active-low reset
//   hold         1 = grant nothing this cycle
//   req_valid    per-requester pending write
//   req_addr     per-requester destination register, slice [i*ADDRW +: ADDRW]
//   req_data     per-requester write data, slice [i*DATAWIDTH +: DATAWIDTH]
//   req_ready    combinational grant; a write is accepted on a clk with valid & ready
//   write        registered write enable
//   writeReg1/2  registered port addresses
//   writeData1/2 registered port data
//   stat_writes  (WR_ARB_STATS_EN only) saturating count of granted writes
//   stat_stalls  (WR_ARB_STATS_EN only) saturating count of cycles with an ungranted valid request
//
// Optional feature macro: WR_ARB_STATS_EN

module regfile_wr_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int NREQ      = 4,
    parameter int ADDRW     = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      hold,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*ADDRW-1:0]     req_addr,
    input  logic [NREQ*DATAWIDTH-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      write,
    output logic [ADDRW-1:0]          writeReg1,
    output logic [ADDRW-1:0]          writeReg2,
    output logic [DATAWIDTH-1:0]      writeData1,
    output logic [DATAWIDTH-1:0]      writeData2
`ifdef WR_ARB_STATS_EN
    ,
    output logic [31:0]               stat_writes,
    output logic [31:0]               stat_stalls
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // One extra bit so rr_ptr + offset can be reduced modulo NREQ.
    localparam int SW = PW + 1;

    logic [PW-1:0]        r_rr_ptr;
    logic                 r_write;
    logic [ADDRW-1:0]     r_reg1;
    logic [ADDRW-1:0]     r_reg2;
    logic [DATAWIDTH-1:0] r_data1;
    logic [DATAWIDTH-1:0] r_data2;

    logic                 w_a_found;
    logic                 w_b_found;
    logic [PW-1:0]        w_a_idx;
    logic [PW-1:0]        w_b_idx;
    logic [ADDRW-1:0]     w_a_addr;
    logic [ADDRW-1:0]     w_b_addr;
    logic [DATAWIDTH-1:0] w_a_data;
    logic [DATAWIDTH-1:0] w_b_data;
    logic [NREQ-1:0]      w_ready;
    logic [PW-1:0]        w_last;
    logic [PW-1:0]        w_next_ptr;
    logic [SW-1:0]        w_pos;
    logic [PW-1:0]        w_idx;
    logic [ADDRW-1:0]     w_cand_addr;

    // Scan requesters starting at rr_ptr. The first valid one takes slot A.
    // The next valid one with a different address takes slot B.
    // Requests to slot A's register are skipped and stay pending.
    always_comb begin
        w_a_found   = 1'b0;
        w_b_found   = 1'b0;
        w_a_idx     = '0;
        w_b_idx     = '0;
        w_a_addr    = '0;
        w_b_addr    = '0;
        w_a_data    = '0;
        w_b_data    = '0;
        w_ready     = '0;
        w_pos       = '0;
        w_idx       = '0;
        w_cand_addr = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = {1'b0, r_rr_ptr} + SW'(k);
            if (w_pos >= SW'(NREQ)) begin
                w_pos = w_pos - SW'(NREQ);
            end
            w_idx       = w_pos[PW-1:0];
            w_cand_addr = req_addr[w_idx*ADDRW +: ADDRW];
            if (!hold && req_valid[w_idx]) begin
                if (!w_a_found) begin
                    w_a_found = 1'b1;
                    w_a_idx   = w_idx;
                    w_a_addr  = w_cand_addr;
                    w_a_data  = req_data[w_idx*DATAWIDTH +: DATAWIDTH];
                end else if (!w_b_found && (w_cand_addr != w_a_addr)) begin
                    w_b_found = 1'b1;
                    w_b_idx   = w_idx;
                    w_b_addr  = w_cand_addr;
                    w_b_data  = req_data[w_idx*DATAWIDTH +: DATAWIDTH];
                end
            end
        end
        if (w_a_found) begin
            w_ready[w_a_idx] = 1'b1;
        end
        if (w_b_found) begin
            w_ready[w_b_idx] = 1'b1;
        end
        // Slot B always lies later in scan order than slot A, so it is the last grant.
        w_last     = w_b_found ? w_b_idx : w_a_idx;
        w_next_ptr = (w_last == PW'(NREQ - 1)) ? '0 : w_last + PW'(1);
    end

    assign req_ready = w_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr <= '0;
            r_write  <= 1'b0;
            r_reg1   <= '0;
            r_reg2   <= '0;
            r_data1  <= '0;
            r_data2  <= '0;
        end else begin
            r_write <= w_a_found;
            if (w_a_found) begin
                r_rr_ptr <= w_next_ptr;
                r_reg1   <= w_a_addr;
                r_data1  <= w_a_data;
                // Both ports are written whenever write=1.
                // With a single grant, port 2 repeats port 1.
                r_reg2   <= w_b_found ? w_b_addr : w_a_addr;
                r_data2  <= w_b_found ? w_b_data : w_a_data;
            end
        end
    end

    assign write      = r_write;
    assign writeReg1  = r_reg1;
    assign writeReg2  = r_reg2;
    assign writeData1 = r_data1;
    assign writeData2 = r_data2;

`ifdef WR_ARB_STATS_EN
    logic [31:0] r_stat_writes;
    logic [31:0] r_stat_stalls;
    logic [32:0] w_writes_sum;
    logic [32:0] w_stalls_sum;
    logic [1:0]  w_grants;
    logic        w_stall;

    always_comb begin
        w_grants     = {1'b0, w_a_found} + {1'b0, w_b_found};
        w_stall      = |(req_valid & ~w_ready);
        w_writes_sum = {1'b0, r_stat_writes} + {31'd0, w_grants};
        w_stalls_sum = {1'b0, r_stat_stalls} + {32'd0, w_stall};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stat_writes <= '0;
            r_stat_stalls <= '0;
        end else begin
            r_stat_writes <= w_writes_sum[32] ? 32'hFFFF_FFFF : w_writes_sum[31:0];
            r_stat_stalls <= w_stalls_sum[32] ? 32'hFFFF_FFFF : w_stalls_sum[31:0];
        end
    end

    assign stat_writes = r_stat_writes;
    assign stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int AW   = 4;

    logic              clk;
    logic              resetn;
    logic              hold;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              write;
    logic [AW-1:0]     writeReg1;
    logic [AW-1:0]     writeReg2;
    logic [DW-1:0]     writeData1;
    logic [DW-1:0]     writeData2;
`ifdef WR_ARB_STATS_EN
    logic [31:0]       stat_writes;
    logic [31:0]       stat_stalls;
`endif

    regfile_wr_arbiter #(.DATAWIDTH(DW), .NREQ(NREQ), .ADDRW(AW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .hold       (hold),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .write      (write),
        .writeReg1  (writeReg1),
        .writeReg2  (writeReg2),
        .writeData1 (writeData1),
        .writeData2 (writeData2)
`ifdef WR_ARB_STATS_EN
        ,
        .stat_writes(stat_writes),
        .stat_stalls(stat_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    localparam logic [31:0] D0 = 32'hA5A5_0000;
    localparam logic [31:0] D1 = 32'hA5A5_0001;
    localparam logic [31:0] D2 = 32'hA5A5_0002;
    localparam logic [31:0] D3 = 32'hA5A5_0003;

    typedef struct {
        logic        hold;
        logic [3:0]  valid;
        logic [15:0] addrs;
        logic [3:0]  ready;
        logic        wr;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic [31:0] d1;
        logic [31:0] d2;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic h, input logic [3:0] v, input logic [15:0] a,
                                input logic [3:0] rdy, input logic w, input logic [3:0] r1,
                                input logic [3:0] r2, input logic [31:0] d1, input logic [31:0] d2);
        vec_t t;
        t.hold = h; t.valid = v; t.addrs = a; t.ready = rdy; t.wr = w;
        t.r1 = r1; t.r2 = r2; t.d1 = d1; t.d2 = d2;
        return t;
    endfunction

    // Reference model state
    int          m_ptr;
    logic        m_write;
    logic [3:0]  m_r1, m_r2;
    logic [31:0] m_d1, m_d2;
    logic        rv[NREQ];
    logic [3:0]  ra[NREQ];
    logic [31:0] rd[NREQ];

    task automatic drive_model_inputs(input logic h);
        hold = h;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = rv[i];
            req_addr[i*AW +: AW]  = ra[i];
            req_data[i*DW +: DW]  = rd[i];
        end
    endtask

    // Grants: list valid requesters in rotation order from the pointer.
    // A is the first entry; B is the first later entry with a different register.
    task automatic model_grant(input logic h, output int ga, output int gb);
        int order[$];
        ga = -1;
        gb = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (rv[(m_ptr + k) % NREQ]) order.push_back((m_ptr + k) % NREQ);
        end
        if (!h && order.size() > 0) begin
            ga = order[0];
            foreach (order[j]) begin
                if (gb < 0 && ra[order[j]] != ra[ga]) gb = order[j];
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] dpack;
        int ga, gb;
        logic [3:0] exp_rdy;
        dpack = {D3, D2, D1, D0};

        tbl[0]  = mk(0, 4'b1111, 16'h4321, 4'b0011, 1, 1, 2, D0, D1);
        tbl[1]  = mk(0, 4'b1111, 16'h4321, 4'b1100, 1, 3, 4, D2, D3);
        tbl[2]  = mk(0, 4'b1111, 16'h4321, 4'b0011, 1, 1, 2, D0, D1);
        tbl[3]  = mk(1, 4'b1111, 16'h4321, 4'b0000, 0, 1, 2, D0, D1);
        tbl[4]  = mk(1, 4'b1111, 16'h4321, 4'b0000, 0, 1, 2, D0, D1);
        tbl[5]  = mk(1, 4'b1111, 16'h4321, 4'b0000, 0, 1, 2, D0, D1);
        tbl[6]  = mk(0, 4'b1111, 16'h4321, 4'b1100, 1, 3, 4, D2, D3);
        tbl[7]  = mk(0, 4'b0100, 16'h0500, 4'b0100, 1, 5, 5, D2, D2);
        tbl[8]  = mk(0, 4'b0011, 16'h0077, 4'b0001, 1, 7, 7, D0, D0);
        tbl[9]  = mk(0, 4'b0010, 16'h0070, 4'b0010, 1, 7, 7, D1, D1);
        tbl[10] = mk(0, 4'b1001, 16'h9009, 4'b1000, 1, 9, 9, D3, D3);
        tbl[11] = mk(0, 4'b0000, 16'h0000, 4'b0000, 0, 9, 9, D3, D3);
        tbl[12] = mk(0, 4'b1111, 16'h6666, 4'b0001, 1, 6, 6, D0, D0);
        tbl[13] = mk(0, 4'b1110, 16'h6666, 4'b0010, 1, 6, 6, D1, D1);
        tbl[14] = mk(0, 4'b1100, 16'h6666, 4'b0100, 1, 6, 6, D2, D2);
        tbl[15] = mk(0, 4'b1000, 16'h6666, 4'b1000, 1, 6, 6, D3, D3);

        // Reset with every requester valid: outputs are zero during reset.
        resetn    = 1'b0;
        hold      = 1'b0;
        req_valid = 4'b1111;
        req_addr  = 16'h4321;
        req_data  = dpack;
        @(posedge clk); @(posedge clk); #2;
        chk("reset_write", 64'(write), 64'd0);
        chk("reset_reg1",  64'(writeReg1), 64'd0);
        chk("reset_reg2",  64'(writeReg2), 64'd0);
        chk("reset_data1", 64'(writeData1), 64'd0);
        chk("reset_data2", 64'(writeData2), 64'd0);
        resetn = 1'b1;

        // Directed table, starting from rr_ptr=0 right after reset.
        for (int t = 0; t < 16; t++) begin
            hold      = tbl[t].hold;
            req_valid = tbl[t].valid;
            req_addr  = tbl[t].addrs;
            req_data  = dpack;
            #1;
            chk($sformatf("tbl%0d_ready", t), 64'(req_ready), 64'(tbl[t].ready));
            @(posedge clk); #2;
            chk($sformatf("tbl%0d_write", t), 64'(write), 64'(tbl[t].wr));
            chk($sformatf("tbl%0d_reg1", t), 64'(writeReg1), 64'(tbl[t].r1));
            chk($sformatf("tbl%0d_reg2", t), 64'(writeReg2), 64'(tbl[t].r2));
            chk($sformatf("tbl%0d_data1", t), 64'(writeData1), 64'(tbl[t].d1));
            chk($sformatf("tbl%0d_data2", t), 64'(writeData2), 64'(tbl[t].d2));
`ifdef WR_ARB_STATS_EN
            if (t == 2) begin
                chk("stat_writes", 64'(stat_writes), 64'd6);
                chk("stat_stalls", 64'(stat_stalls), 64'd3);
            end
`endif
        end

        // Reset pulsed mid-stream after a grant: bus clears at once, lost write re-granted.
        hold      = 1'b0;
        req_valid = 4'b1111;
        req_addr  = 16'h4321;
        #1;
        chk("mid_ready", 64'(req_ready), 64'b0011);
        @(posedge clk); #2;
        chk("mid_write_before", 64'(write), 64'd1);
        resetn = 1'b0;
        #1;
        chk("mid_async_write", 64'(write), 64'd0);
        chk("mid_async_reg1",  64'(writeReg1), 64'd0);
        chk("mid_async_data2", 64'(writeData2), 64'd0);
        @(posedge clk); #2;
        resetn = 1'b1;
        #1;
        chk("mid_regrant_ready", 64'(req_ready), 64'b0011);
        @(posedge clk); #2;
        chk("mid_regrant_reg1", 64'(writeReg1), 64'd1);
        chk("mid_regrant_reg2", 64'(writeReg2), 64'd2);

        // Randomized traffic against the reference model.
        resetn = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b0;
            ra[i] = '0;
            rd[i] = '0;
        end
        drive_model_inputs(1'b0);
        @(posedge clk); #2;
        resetn  = 1'b1;
        m_ptr   = 0;
        m_write = 1'b0;
        m_r1 = '0; m_r2 = '0; m_d1 = '0; m_d2 = '0;

        for (int c = 0; c < 1500; c++) begin
            logic h;
            h = ($urandom_range(0, 4) == 0);
            drive_model_inputs(h);
            model_grant(h, ga, gb);
            exp_rdy = '0;
            if (ga >= 0) exp_rdy[ga] = 1'b1;
            if (gb >= 0) exp_rdy[gb] = 1'b1;
            #1;
            chk("rnd_ready", 64'(req_ready), 64'(exp_rdy));
            @(posedge clk); #2;
            m_write = (ga >= 0);
            if (ga >= 0) begin
                m_r1  = ra[ga];
                m_d1  = rd[ga];
                m_r2  = (gb >= 0) ? ra[gb] : ra[ga];
                m_d2  = (gb >= 0) ? rd[gb] : rd[ga];
                m_ptr = (((gb >= 0) ? gb : ga) + 1) % NREQ;
            end
            chk("rnd_write", 64'(write), 64'(m_write));
            chk("rnd_reg1",  64'(writeReg1), 64'(m_r1));
            chk("rnd_reg2",  64'(writeReg2), 64'(m_r2));
            chk("rnd_data1", 64'(writeData1), 64'(m_d1));
            chk("rnd_data2", 64'(writeData2), 64'(m_d2));
            // Granted requesters may pick up new work; pending ones hold steady.
            for (int i = 0; i < NREQ; i++) begin
                if ((i == ga) || (i == gb) || !rv[i]) begin
                    rv[i] = ($urandom_range(0, 3) != 0);
                    ra[i] = 4'($urandom_range(0, 3));
                    rd[i] = $urandom;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
